wb_retire_queue: RTL and testbench

//  Parametrised writeback stage for the pipelined core with variable-latency data memory.

---
 rtl/wb_retire_queue.sv | 179 +++++++++++++++++
 tb/tb_wb_retire_queue.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_queue.sv
// -----------------------------------------------------------------------------
// wb_retire_queue
//
// Writeback stage that sits between a variable-latency MEM stage and the
// register file. MEM/WB entries are held in an in-order circular queue. Load
// entries wait for their data-memory response. Responses come back in load
// issue order. A response that cannot be used in the cycle it arrives is parked
// in a small response FIFO. The head entry retires at most once per cycle, and
// load data is sign- or zero-extended according to funct3.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/ready    MEM-stage handshake; in_ready is low only when full
//   in_rd, in_we      destination register and write enable of the entry
//   in_is_load        result comes from dmem instead of in_result
//   in_funct3         load type (RISC-V funct3)
//   in_addr_lo        low address bits used to select the byte/half/word lane
//   in_result         precomputed non-load result
//   in_order          RVFI order tag, carried through to retire_order
//   dmem_resp/rdata   one in-order response per issued load
//   retire_valid      head entry retires this cycle
//   regf_we, rd_sel   register-file write port (rd_sel is 0 when idle)
//   rd_v              formatted write data (0 when idle)
//   retire_order      order tag of the retiring entry (0 when idle)
//   occupancy         number of entries held
//   err               sticky: spurious response or illegal load funct3
// -----------------------------------------------------------------------------
module wb_retire_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic                     in_we,
    input  logic                     in_is_load,
    input  logic [2:0]               in_funct3,
    input  logic [2:0]               in_addr_lo,
    input  logic [XLEN-1:0]          in_result,
    input  logic [63:0]              in_order,
    input  logic                     dmem_resp,
    input  logic [XLEN-1:0]          dmem_rdata,
    output logic                     retire_valid,
    output logic                     regf_we,
    output logic [4:0]               rd_sel,
    output logic [XLEN-1:0]          rd_v,
    output logic [63:0]              retire_order,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err
);

    localparam int PW   = $clog2(DEPTH);
    localparam int OFFW = $clog2(XLEN / 8);
    localparam int SHW  = OFFW + 3;
    // Shift amounts are byte offsets times 8; these masks round the shift
    // down to a halfword or word boundary.
    localparam logic [SHW-1:0] HALF_MASK = ~SHW'(15);
    localparam logic [SHW-1:0] WORD_MASK = ~SHW'(31);

    // Entry queue storage.
    logic [4:0]       q_rd      [DEPTH];
    logic             q_we      [DEPTH];
    logic             q_is_load [DEPTH];
    logic [2:0]       q_funct3  [DEPTH];
    logic [OFFW-1:0]  q_off     [DEPTH];
    logic [XLEN-1:0]  q_result  [DEPTH];
    logic [63:0]      q_order   [DEPTH];
    logic [PW-1:0]    q_head, q_tail;
    logic [PW:0]      q_count;
    logic [PW:0]      load_count;   // load entries currently in the queue

    // Response buffer storage.
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [PW-1:0]    r_head, r_tail;
    logic [PW:0]      r_count;

    // Only the lane-select bits of in_addr_lo matter for narrow XLEN.
    logic unused_addr;
    assign unused_addr = ^in_addr_lo;

    // Head view and control.
    logic             enq, head_valid, buf_valid, retire, ret_load;
    logic             pop_buf, bypass, push_buf, spurious, f3_bad;
    logic [PW:0]      pend_loads;
    logic [XLEN-1:0]  ld_data, fmt;
    logic [XLEN-1:0]  byte_sh, half_sh, word_sh;
    logic [SHW-1:0]   sh_b;

    assign in_ready   = (q_count != (PW+1)'(DEPTH));
    assign enq        = in_valid & in_ready;
    assign head_valid = (q_count != '0);
    assign buf_valid  = (r_count != '0);

    // A load at the head may use a parked response or the one arriving now.
    assign retire   = head_valid & (~q_is_load[q_head] | buf_valid | dmem_resp);
    assign ret_load = retire & q_is_load[q_head];
    assign pop_buf  = ret_load & buf_valid;
    assign bypass   = ret_load & ~buf_valid;

    // Loads still owed a response. A response with nobody waiting is dropped.
    assign pend_loads = load_count - r_count;
    assign spurious   = dmem_resp & (pend_loads == '0);
    assign push_buf   = dmem_resp & ~bypass & ~spurious;

    // Parked responses are older than the one on the bus, so they go first.
    assign ld_data = buf_valid ? r_data[r_head] : dmem_rdata;

    assign sh_b    = {q_off[q_head], 3'b000};
    assign byte_sh = ld_data >> sh_b;
    assign half_sh = ld_data >> (sh_b & HALF_MASK);
    assign word_sh = ld_data >> (sh_b & WORD_MASK);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statement can infer a latch.
    always_comb begin
        fmt    = '0;
        f3_bad = 1'b0;
        unique case (q_funct3[q_head])
            3'b000: fmt = XLEN'($signed(byte_sh[7:0]));
            3'b100: fmt = XLEN'(byte_sh[7:0]);
            3'b001: fmt = XLEN'($signed(half_sh[15:0]));
            3'b101: fmt = XLEN'(half_sh[15:0]);
            3'b010: fmt = XLEN'($signed(word_sh[31:0]));
            3'b110: if (XLEN == 64) fmt = XLEN'(word_sh[31:0]); else f3_bad = 1'b1;
            3'b011: if (XLEN == 64) fmt = ld_data;              else f3_bad = 1'b1;
            default: f3_bad = 1'b1;
        endcase
    end

    assign retire_valid = retire;
    assign regf_we      = retire & q_we[q_head] & (q_rd[q_head] != 5'd0);
    assign rd_sel       = retire ? q_rd[q_head] : 5'd0;
    assign rd_v         = !retire           ? '0 :
                          q_is_load[q_head] ? fmt : q_result[q_head];
    assign retire_order = retire ? q_order[q_head] : 64'd0;
    assign occupancy    = q_count;

    // NOTE: state registers use non-blocking assignments so every block reads
    // the pre-edge values, no matter what order the simulator runs them in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_head     <= '0;
            q_tail     <= '0;
            q_count    <= '0;
            load_count <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            err        <= 1'b0;
        end else begin
            if (enq)      q_tail <= q_tail + 1'b1;
            if (retire)   q_head <= q_head + 1'b1;
            if (push_buf) r_tail <= r_tail + 1'b1;
            if (pop_buf)  r_head <= r_head + 1'b1;
            q_count    <= q_count + (PW+1)'(enq) - (PW+1)'(retire);
            load_count <= load_count + (PW+1)'(enq & in_is_load) - (PW+1)'(ret_load);
            r_count    <= r_count + (PW+1)'(push_buf) - (PW+1)'(pop_buf);
            err        <= err | spurious | (ret_load & f3_bad);
        end
    end

    // NOTE: storage arrays are not reset. The pointers and counts define which
    // slots are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[q_tail]      <= in_rd;
            q_we[q_tail]      <= in_we;
            q_is_load[q_tail] <= in_is_load;
            q_funct3[q_tail]  <= in_funct3;
            q_off[q_tail]     <= in_addr_lo[OFFW-1:0];
            q_result[q_tail]  <= in_result;
            q_order[q_tail]   <= in_order;
        end
        if (push_buf) r_data[r_tail] <= dmem_rdata;
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_retire_queue
//
// Directed scenarios followed by a randomized phase. Every cycle's outputs are
// compared against a queue-based reference model of the writeback stage.
// -----------------------------------------------------------------------------
module tb_wb_retire_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [4:0]             in_rd = '0;
    logic                   in_we = 1'b0;
    logic                   in_is_load = 1'b0;
    logic [2:0]             in_funct3 = '0;
    logic [2:0]             in_addr_lo = '0;
    logic [XLEN-1:0]        in_result = '0;
    logic [63:0]            in_order = '0;
    logic                   dmem_resp = 1'b0;
    logic [XLEN-1:0]        dmem_rdata = '0;
    logic                   retire_valid, regf_we, err;
    logic [4:0]             rd_sel;
    logic [XLEN-1:0]        rd_v;
    logic [63:0]            retire_order;
    logic [$clog2(DEPTH):0] occupancy;

    wb_retire_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_we(in_we),
        .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .in_result(in_result), .in_order(in_order),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .retire_valid(retire_valid), .regf_we(regf_we), .rd_sel(rd_sel),
        .rd_v(rd_v), .retire_order(retire_order), .occupancy(occupancy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic            we;
        logic            is_load;
        logic [2:0]      f3;
        logic [2:0]      alo;
        logic [XLEN-1:0] res;
        logic [63:0]     ord;
    } ent_t;

    ent_t            mq[$];   // model entry queue
    logic [XLEN-1:0] mr[$];   // model parked responses
    bit              merr;
    int              passes = 0;
    int              fails  = 0;
    int              total  = 0;
    logic [63:0]     ord_ctr = 64'h100;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load formatting from the RISC-V rules, in plain 64-bit arithmetic.
    function automatic logic [XLEN-1:0] ref_fmt(input logic [2:0] f3, input logic [2:0] alo,
                                                 input logic [XLEN-1:0] d, output bit bad);
        longint unsigned v, r;
        int off;
        v   = 64'(d);
        off = int'(alo) % (XLEN / 8);
        r   = 0;
        bad = 0;
        case (f3)
            3'd0, 3'd4: begin
                r = (v >> (8 * off)) & 64'hFF;
                if (f3 == 3'd0 && r >= 64'd128) r = r - 64'd256;
            end
            3'd1, 3'd5: begin
                r = (v >> (16 * (off / 2))) & 64'hFFFF;
                if (f3 == 3'd1 && r >= 64'd32768) r = r - 64'd65536;
            end
            3'd2: begin
                r = (v >> (32 * (off / 4))) & 64'hFFFF_FFFF;
                if (r >= 64'h8000_0000) r = r - 64'h1_0000_0000;
            end
            3'd6: if (XLEN == 64) r = (v >> (32 * (off / 4))) & 64'hFFFF_FFFF; else bad = 1;
            3'd3: if (XLEN == 64) r = v; else bad = 1;
            default: bad = 1;
        endcase
        return r[XLEN-1:0];
    endfunction

    function automatic int model_loads();
        int n = 0;
        foreach (mq[i]) if (mq[i].is_load) n++;
        return n;
    endfunction

    // Compare this cycle's outputs with the model at the falling edge, then
    // advance the model to its post-edge state.
    task automatic sample();
        ent_t h;
        ent_t e;
        bit rdy, hv, hready, had_buf, bad;
        logic [XLEN-1:0] d, ev;
        int pend;
        @(negedge clk);
        rdy     = mq.size() < DEPTH;
        hv      = mq.size() != 0;
        h       = '{default: '0};
        if (hv) h = mq[0];
        had_buf = mr.size() != 0;
        hready  = hv && (!h.is_load || had_buf || dmem_resp);
        d       = had_buf ? mr[0] : dmem_rdata;
        ev      = '0;
        bad     = 0;
        if (hready) begin
            if (h.is_load) ev = ref_fmt(h.f3, h.alo, d, bad);
            else           ev = h.res;
        end
        check("in_ready",     in_ready,     rdy);
        check("occupancy",    occupancy,    mq.size());
        check("retire_valid", retire_valid, hready);
        check("regf_we",      regf_we,      hready && h.we && (h.rd != 0));
        check("rd_sel",       rd_sel,       hready ? h.rd : 5'd0);
        check("rd_v",         rd_v,         ev);
        check("retire_order", retire_order, hready ? h.ord : 64'd0);
        check("err",          err,          merr);

        pend = model_loads() - mr.size();
        if (hready) begin
            if (h.is_load && had_buf) mr.delete(0);
            if (h.is_load && bad) merr = 1;
            mq.delete(0);
        end
        if (dmem_resp && !(hready && h.is_load && !had_buf)) begin
            if (pend > 0) mr.push_back(dmem_rdata);
            else          merr = 1;
        end
        if (in_valid && rdy) begin
            e.rd = in_rd; e.we = in_we; e.is_load = in_is_load; e.f3 = in_funct3;
            e.alo = in_addr_lo; e.res = in_result; e.ord = in_order;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic set_in(input logic [4:0] rd, input logic ld, input logic [2:0] f3,
                          input logic [2:0] alo, input logic [XLEN-1:0] res);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_we      = 1'b1;
        in_is_load = ld;
        in_funct3  = f3;
        in_addr_lo = alo;
        in_result  = res;
        in_order   = ord_ctr;
        ord_ctr    = ord_ctr + 1;
    endtask

    task automatic resp(input logic v, input logic [XLEN-1:0] d);
        dmem_resp  = v;
        dmem_rdata = d;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        dmem_resp = 1'b0;
        rst_n     = 1'b0;
        #3;
        mq.delete();
        mr.delete();
        merr = 0;
        check("rst_in_ready",     in_ready,     1'b1);
        check("rst_occupancy",    occupancy,    0);
        check("rst_retire_valid", retire_valid, 1'b0);
        check("rst_regf_we",      regf_we,      1'b0);
        check("rst_rd_sel",       rd_sel,       5'd0);
        check("rst_rd_v",         rd_v,         0);
        check("rst_retire_order", retire_order, 64'd0);
        check("rst_err",          err,          1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int pend;
        int k;
        logic [2:0] f3s [5];
        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4; f3s[4] = 3'd5;

        do_reset();

        // ALU entry retires the cycle after it is accepted.
        set_in(5'd5, 1'b0, 3'd0, 3'd0, 32'h1234);
        step();
        in_valid = 1'b0;
        sample();
        check("t1_retire", retire_valid, 1'b1);
        check("t1_we",     regf_we,      1'b1);
        check("t1_rd",     rd_sel,       5'd5);
        check("t1_rdv",    rd_v,         32'h1234);
        tick();
        sample();
        check("t1_idle_valid", retire_valid, 1'b0);
        check("t1_idle_rdv",   rd_v,         0);
        tick();

        // LB at byte 3 with the response three cycles later, then LHU at half 1.
        set_in(5'd6, 1'b1, 3'd0, 3'd3, '0);
        step();
        in_valid = 1'b0;
        step();
        step();
        resp(1'b1, 32'h80FF_FF00);
        sample();
        check("t2_lb", rd_v, 32'hFFFF_FF80);
        tick();
        resp(1'b0, '0);
        set_in(5'd7, 1'b1, 3'd5, 3'd2, '0);
        step();
        in_valid = 1'b0;
        resp(1'b1, 32'h80FF_FF00);
        sample();
        check("t2_lhu", rd_v, 32'h0000_80FF);
        tick();
        resp(1'b0, '0);

        // LW, ALU, LW. The second response is parked while the ALU entry retires.
        set_in(5'd8, 1'b1, 3'd2, 3'd0, '0);
        step();
        set_in(5'd9, 1'b0, 3'd0, 3'd0, 32'h55);
        step();
        set_in(5'd10, 1'b1, 3'd2, 3'd0, '0);
        step();
        in_valid = 1'b0;
        resp(1'b1, 32'hDEAD_BEEF);
        sample();
        check("t3_a", rd_v, 32'hDEAD_BEEF);
        tick();
        resp(1'b1, 32'h1234_5678);
        sample();
        check("t3_b", rd_v, 32'h55);
        tick();
        resp(1'b0, '0);
        sample();
        check("t3_c", rd_v, 32'h1234_5678);
        tick();

        // Fill with loads, then retire one while MEM is still presenting.
        for (int i = 1; i <= DEPTH; i++) begin
            set_in(5'(i), 1'b1, 3'd2, 3'd0, '0);
            step();
        end
        in_valid = 1'b0;
        sample();
        check("t4_full_ready", in_ready,  1'b0);
        check("t4_full_occ",   occupancy, DEPTH);
        tick();
        set_in(5'd20, 1'b0, 3'd0, 3'd0, 32'h77);
        resp(1'b1, 32'h0000_0001);
        sample();
        check("t4_retire", retire_valid, 1'b1);
        tick();
        in_valid = 1'b0;
        resp(1'b0, '0);
        sample();
        check("t4_ready_again", in_ready, 1'b1);
        tick();
        for (int i = 0; i < DEPTH - 1; i++) begin
            resp(1'b1, 32'(i + 2));
            step();
        end
        resp(1'b0, '0);

        // Illegal funct3 on a load retires with zero data and flags an error.
        set_in(5'd11, 1'b1, 3'd7, 3'd0, '0);
        step();
        in_valid = 1'b0;
        resp(1'b1, 32'hCAFE_F00D);
        sample();
        check("t5_bad_f3_valid", retire_valid, 1'b1);
        check("t5_bad_f3_rdv",   rd_v,         0);
        tick();
        resp(1'b0, '0);
        sample();
        check("t5_bad_f3_err", err, 1'b1);
        tick();
        do_reset();

        // Spurious response on an empty queue.
        resp(1'b1, 32'hAAAA_5555);
        sample();
        check("t5_spur_noretire", retire_valid, 1'b0);
        tick();
        resp(1'b0, '0);
        step();
        step();
        check("t5_spur_sticky", err, 1'b1);

        // Reset with three entries and one parked response.
        do_reset();
        set_in(5'd12, 1'b1, 3'd2, 3'd0, '0);
        step();
        set_in(5'd13, 1'b0, 3'd0, 3'd0, 32'h99);
        step();
        set_in(5'd14, 1'b1, 3'd2, 3'd0, '0);
        step();
        set_in(5'd15, 1'b1, 3'd2, 3'd0, '0);
        step();
        in_valid = 1'b0;
        resp(1'b1, 32'h1111_1111);
        step();
        set_in(5'd16, 1'b1, 3'd2, 3'd0, '0);
        resp(1'b1, 32'h2222_2222);
        step();
        in_valid = 1'b0;
        resp(1'b0, '0);
        check("t6_pre_rst_occ", occupancy, 3);
        do_reset();
        set_in(5'd17, 1'b0, 3'd0, 3'd0, 32'h4242);
        step();
        in_valid = 1'b0;
        sample();
        check("t6_resume", rd_v, 32'h4242);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_rd      = 5'($urandom_range(0, 31));
            in_we      = 1'($urandom_range(0, 3) != 0);
            in_is_load = 1'($urandom_range(0, 1));
            k          = $urandom_range(0, 4);
            in_funct3  = f3s[k];
            in_addr_lo = 3'($urandom_range(0, 3));
            if (in_funct3 == 3'd1 || in_funct3 == 3'd5) in_addr_lo[0] = 1'b0;
            if (in_funct3 == 3'd2) in_addr_lo = 3'd0;
            in_result  = $urandom;
            in_order   = ord_ctr;
            ord_ctr    = ord_ctr + 1;
            pend       = model_loads() - mr.size();
            dmem_resp  = (pend > 0) && ($urandom_range(0, 1) == 1);
            dmem_rdata = $urandom;
            step();
        end
        in_valid  = 1'b0;
        dmem_resp = 1'b0;
        step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
